// File: rtl/boot_pkg.sv
// Shared types and constants for the boot-ROM-to-RAM copy controller.
package boot_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_WIDTH     = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } boot_state_e;
endpackage

// File: rtl/boot_copy_ctrl_if.sv
// Bundle of start/status, boot-ROM read and RAM write signals; master is the copy controller.
interface boot_copy_ctrl_if #(
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 16
);
  import boot_pkg::*;

  logic                      start;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [7:0]                rom_data;
  logic                      ram_wvalid;
  logic                      ram_wready;
  logic [RAM_ADDR_WIDTH-1:0] ram_waddr;
  logic [WORD_WIDTH-1:0]     ram_wdata;
  logic [BYTES_PER_WORD-1:0] ram_wstrb;
  logic                      busy;
  logic                      done;
  logic                      cpu_rst_n;

  modport master (
    input  start, rom_data, ram_wready,
    output rom_addr, ram_wvalid, ram_waddr, ram_wdata, ram_wstrb, busy, done, cpu_rst_n
  );

  modport slave (
    output start, rom_data, ram_wready,
    input  rom_addr, ram_wvalid, ram_waddr, ram_wdata, ram_wstrb, busy, done, cpu_rst_n
  );
endinterface

// File: rtl/boot_word_packer.sv
// Assembles ROM bytes into a little-endian 32-bit word with per-lane strobes; one-cycle load.
// Clear has priority over load and zeroes both data and strobes so unfilled lanes read 0.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load,
  input  logic                      i_clear,
  input  logic [1:0]                i_lane,
  input  logic [7:0]                i_byte,
  output logic [WORD_WIDTH-1:0]     o_data,
  output logic [BYTES_PER_WORD-1:0] o_strb
);
  logic [WORD_WIDTH-1:0]     r_data;
  logic [BYTES_PER_WORD-1:0] r_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_strb <= '0;
    end else if (i_clear) begin
      r_data <= '0;
      r_strb <= '0;
    end else if (i_load) begin
      r_data[{i_lane, 3'b000} +: 8] <= i_byte;
      r_strb[i_lane]                <= 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_strb = r_strb;
endmodule

// File: rtl/boot_copy_ctrl.sv
// Copies COPY_LEN boot-ROM bytes into RAM as packed words, holding the CPU in reset until done.
// Each byte costs a fetch and a capture cycle; a word write stalls in WRITE until ram_wready.
module boot_copy_ctrl
  import boot_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int COPY_LEN       = 256,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_BASE       = 0
) (
  input logic              clk,
  input logic              rst_n,
  boot_copy_ctrl_if.master bus
);
  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_IDX = ROM_ADDR_WIDTH'(COPY_LEN - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] BASE     = RAM_ADDR_WIDTH'(RAM_BASE);

  boot_state_e               r_state;
  logic [ROM_ADDR_WIDTH-1:0] r_idx;
  logic [ROM_ADDR_WIDTH-1:0] r_rom_addr;
  logic [RAM_ADDR_WIDTH-1:0] r_waddr;
  logic                      r_wvalid;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_cpu_rst_n;

  logic                      w_last;
  logic                      w_word_end;
  logic                      w_accept;
  logic                      w_start;
  logic                      w_load;
  logic                      w_clear;
  logic [ROM_ADDR_WIDTH-1:0] w_idx_nxt;
  logic [WORD_WIDTH-1:0]     w_wdata;
  logic [BYTES_PER_WORD-1:0] w_wstrb;

  assign w_last     = (r_idx == LAST_IDX);
  assign w_word_end = (&r_idx[1:0]) || w_last;
  assign w_idx_nxt  = r_idx + ROM_ADDR_WIDTH'(1);
  assign w_accept   = (r_state == S_WRITE) && bus.ram_wready;
  assign w_start    = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
  assign w_load     = (r_state == S_CAPTURE);
  // The final word is left in the packer after DONE; a restart clears it.
  assign w_clear    = w_start || (w_accept && !w_last);

  boot_word_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_lane  (r_idx[1:0]),
    .i_byte  (bus.rom_data),
    .o_data  (w_wdata),
    .o_strb  (w_wstrb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rom_addr  <= '0;
      r_waddr     <= BASE;
      r_wvalid    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state     <= S_FETCH;
            r_idx       <= '0;
            r_rom_addr  <= '0;
            r_waddr     <= BASE;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
          end
        end
        S_FETCH: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          if (w_word_end) begin
            r_state  <= S_WRITE;
            r_wvalid <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_idx      <= w_idx_nxt;
            r_rom_addr <= w_idx_nxt;
          end
        end
        S_WRITE: begin
          if (bus.ram_wready) begin
            r_wvalid <= 1'b0;
            if (w_last) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_idx      <= w_idx_nxt;
              r_rom_addr <= w_idx_nxt;
              r_waddr    <= r_waddr + RAM_ADDR_WIDTH'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.ram_wvalid = r_wvalid;
  assign bus.ram_waddr  = r_waddr;
  assign bus.ram_wdata  = w_wdata;
  assign bus.ram_wstrb  = w_wstrb;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.cpu_rst_n  = r_cpu_rst_n;

  // Silences unused-state-bit concerns: w_accept documents the handshake used above.
  logic w_unused;
  assign w_unused = w_accept;
endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Scoreboard bench: instance A (8 bytes, base 0xFFFF, wraps) and instance B (6 bytes, partial word).
module tb_boot_copy_ctrl;
  import boot_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  boot_copy_ctrl_if #(.ROM_ADDR_WIDTH(8), .RAM_ADDR_WIDTH(16)) bus_a ();
  boot_copy_ctrl_if #(.ROM_ADDR_WIDTH(8), .RAM_ADDR_WIDTH(16)) bus_b ();

  boot_copy_ctrl #(.ROM_ADDR_WIDTH(8), .COPY_LEN(8), .RAM_ADDR_WIDTH(16), .RAM_BASE(16'hFFFF)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  boot_copy_ctrl #(.ROM_ADDR_WIDTH(8), .COPY_LEN(6), .RAM_ADDR_WIDTH(16), .RAM_BASE(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  logic [7:0] rom_a [256];
  logic [7:0] rom_b [256];
  always @(posedge clk) bus_a.rom_data <= rom_a[bus_a.rom_addr];
  always @(posedge clk) bus_b.rom_data <= rom_b[bus_b.rom_addr];

  int  n_cmp = 0;
  int  n_err = 0;
  int  wr_cnt_a = 0;
  int  wr_cnt_b = 0;
  wr_t q_a[$];
  wr_t q_b[$];
  wr_t e_a, e_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_a.ram_wvalid && bus_a.ram_wready) begin
      chk("a_write_expected", 64'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        chk("a_waddr", bus_a.ram_waddr, e_a.addr);
        chk("a_wdata", bus_a.ram_wdata, e_a.data);
        chk("a_wstrb", bus_a.ram_wstrb, e_a.strb);
      end
      wr_cnt_a++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_b.ram_wvalid && bus_b.ram_wready) begin
      chk("b_write_expected", 64'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        chk("b_waddr", bus_b.ram_waddr, e_b.addr);
        chk("b_wdata", bus_b.ram_wdata, e_b.data);
        chk("b_wstrb", bus_b.ram_wstrb, e_b.strb);
      end
      wr_cnt_b++;
    end
  end

  function automatic logic done_of(input bit sel);
    return sel ? bus_b.done : bus_a.done;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? bus_b.busy : bus_a.busy;
  endfunction
  function automatic logic cpu_of(input bit sel);
    return sel ? bus_b.cpu_rst_n : bus_a.cpu_rst_n;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) bus_b.start = v;
    else     bus_a.start = v;
  endtask

  // Returns #1 after the edge that samples start.
  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
  endtask

  task automatic run_copy(input bit sel, input int exp_cycles, input bit poke);
    int c;
    pulse_start(sel);
    chk("start_busy", busy_of(sel), 1);
    chk("start_done_low", done_of(sel), 0);
    chk("start_cpu_rst_low", cpu_of(sel), 0);
    for (c = 1; c <= exp_cycles + 20; c++) begin
      if (poke && c == 5) set_start(sel, 1'b1);
      if (poke && c == 6) set_start(sel, 1'b0);
      @(posedge clk); #1;
      if (done_of(sel)) break;
    end
    chk("cycles_to_done", c, exp_cycles);
    chk("done_busy_low", busy_of(sel), 0);
    chk("done_cpu_rst_high", cpu_of(sel), 1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_rom_addr"}, bus_a.rom_addr, 0);
    chk({tag, "_wvalid"}, bus_a.ram_wvalid, 0);
    chk({tag, "_waddr"}, bus_a.ram_waddr, 16'hFFFF);
    chk({tag, "_wdata"}, bus_a.ram_wdata, 0);
    chk({tag, "_wstrb"}, bus_a.ram_wstrb, 0);
    chk({tag, "_busy"}, bus_a.busy, 0);
    chk({tag, "_done"}, bus_a.done, 0);
    chk({tag, "_cpu_rst_n"}, bus_a.cpu_rst_n, 0);
  endtask

  initial begin
    int c;
    int n0;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 8'(i);
      rom_b[i] = 8'(8'h11 + i);
    end
    rst_n            = 1'b0;
    bus_a.start      = 1'b0;
    bus_b.start      = 1'b0;
    bus_a.ram_wready = 1'b1;
    bus_b.ram_wready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a("reset_a");
    chk("reset_b_waddr", bus_b.ram_waddr, 0);
    chk("reset_b_busy", bus_b.busy, 0);
    rst_n = 1'b1;

    // Two full words; second address wraps from 0xFFFF to 0.
    q_a.push_back(wr_t'{16'hFFFF, 32'h03020100, 4'hF});
    q_a.push_back(wr_t'{16'h0000, 32'h07060504, 4'hF});
    run_copy(1'b0, 18, 1'b0);
    chk("copy1_writes", wr_cnt_a, 2);
    chk("copy1_queue_empty", q_a.size(), 0);

    // Restart from DONE with a stray start pulse mid-copy.
    q_a.push_back(wr_t'{16'hFFFF, 32'h03020100, 4'hF});
    q_a.push_back(wr_t'{16'h0000, 32'h07060504, 4'hF});
    run_copy(1'b0, 18, 1'b1);
    chk("copy2_writes", wr_cnt_a, 4);
    chk("copy2_queue_empty", q_a.size(), 0);

    // Back-pressure on the first word write.
    bus_a.ram_wready = 1'b0;
    q_a.push_back(wr_t'{16'hFFFF, 32'h03020100, 4'hF});
    q_a.push_back(wr_t'{16'h0000, 32'h07060504, 4'hF});
    n0 = wr_cnt_a;
    pulse_start(1'b0);
    for (c = 0; c < 40 && !bus_a.ram_wvalid; c++) begin
      @(posedge clk); #1;
    end
    chk("stall_wvalid_seen", bus_a.ram_wvalid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_wvalid", bus_a.ram_wvalid, 1);
      chk("stall_waddr", bus_a.ram_waddr, 16'hFFFF);
      chk("stall_wdata", bus_a.ram_wdata, 32'h03020100);
      chk("stall_wstrb", bus_a.ram_wstrb, 4'hF);
      @(posedge clk); #1;
    end
    chk("stall_no_write", wr_cnt_a, n0);
    bus_a.ram_wready = 1'b1;
    for (c = 0; c < 60 && !bus_a.done; c++) begin
      @(posedge clk); #1;
    end
    chk("stall_done", bus_a.done, 1);
    chk("stall_writes", wr_cnt_a - n0, 2);
    chk("stall_queue_empty", q_a.size(), 0);

    // Reset in the middle of the second word.
    q_a.push_back(wr_t'{16'hFFFF, 32'h03020100, 4'hF});
    n0 = wr_cnt_a;
    pulse_start(1'b0);
    for (c = 0; c < 40 && bus_a.rom_addr != 8'd5; c++) begin
      @(posedge clk); #1;
    end
    chk("midrst_idx5_seen", bus_a.rom_addr, 5);
    rst_n = 1'b0;
    #1;
    chk_reset_a("midrst");
    chk("midrst_first_word", wr_cnt_a - n0, 1);
    chk("midrst_queue_empty", q_a.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_no_resume_writes", wr_cnt_a - n0, 1);
    chk("midrst_no_resume_busy", bus_a.busy, 0);
    chk("midrst_no_resume_done", bus_a.done, 0);

    // Partial final word on instance B.
    q_b.push_back(wr_t'{16'h0000, 32'h14131211, 4'hF});
    q_b.push_back(wr_t'{16'h0001, 32'h00001615, 4'h3});
    run_copy(1'b1, 14, 1'b0);
    chk("partial_writes", wr_cnt_b, 2);
    chk("partial_queue_empty", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
